// File: rtl/cjb_stack_ctrl.sv
// Sequencer/arbiter sharing one DEPTH-entry LIFO stack between two requesters.
// Legal op acks on the 3rd edge after req, rejected op on the 2nd; define CJB_STACK_CTRL_RR_EN for round-robin ties.
module cjb_stack_ctrl #(
  parameter int n     = 8,
  parameter int DEPTH = 4
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         req0,
  input  logic         op0,
  input  logic [n-1:0] wdata0,
  input  logic         req1,
  input  logic         op1,
  input  logic [n-1:0] wdata1,
  output logic         ack0,
  output logic         ack1,
  output logic [n-1:0] rdata,
  output logic         err,
  output logic [2:0]   depth,
  output logic         full,
  output logic         empty,
  output logic         stk_push,
  output logic         stk_pop,
  output logic         stk_rst,
  output logic [n-1:0] stk_din,
  input  logic [n-1:0] stk_dout
);

  typedef enum logic [1:0] {CLR, IDLE, ISSUE, RESP} state_t;

  localparam logic [2:0] DEPTH_MAX = 3'(DEPTH);

  state_t       state, state_nxt;
  logic [2:0]   depth_r;
  logic         gnt_id, gnt_op, err_r;
  logic [n-1:0] din_r;
  logic         any_req, sel, sel_op, illegal;
  logic [n-1:0] sel_dat;

  assign any_req = req0 || req1;

`ifdef CJB_STACK_CTRL_RR_EN
  logic last_gnt;

  // On a tie the port not serviced most recently wins.
  assign sel = (req0 && req1) ? ~last_gnt : req1;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      last_gnt <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_gnt <= sel;
    end
  end
`else
  assign sel = req1;
`endif

  assign sel_op  = sel ? op1 : op0;
  assign sel_dat = sel ? wdata1 : wdata0;
  assign illegal = sel_op ? (depth_r == DEPTH_MAX) : (depth_r == 3'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      CLR:     state_nxt = IDLE;
      IDLE:    if (any_req) state_nxt = illegal ? RESP : ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = CLR;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= CLR;
      depth_r <= 3'd0;
      gnt_id  <= 1'b0;
      gnt_op  <= 1'b0;
      err_r   <= 1'b0;
      din_r   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_id <= sel;
            gnt_op <= sel_op;
            din_r  <= sel_dat;
            err_r  <= illegal;
          end
        end
        ISSUE:   depth_r <= gnt_op ? depth_r + 3'd1 : depth_r - 3'd1;
        RESP:    err_r <= 1'b0;
        default: ;
      endcase
    end
  end

  assign stk_rst  = (state == CLR);
  assign stk_push = (state == ISSUE) && gnt_op;
  assign stk_pop  = (state == ISSUE) && !gnt_op;
  assign stk_din  = din_r;
  assign ack0     = (state == RESP) && !gnt_id;
  assign ack1     = (state == RESP) && gnt_id;
  assign err      = (state == RESP) && err_r;
  // The stack registered the popped word on the ISSUE edge, so dout is valid here.
  assign rdata    = ((state == RESP) && !err_r && !gnt_op) ? stk_dout : '0;
  assign depth    = depth_r;
  assign full     = (depth_r == DEPTH_MAX);
  assign empty    = (depth_r == 3'd0);

endmodule

// File: doc/cjb_stack_ctrl.md
Name: cjb_stack_ctrl

Overview:
- Sequencer and arbiter for the n-bit, 4-location hardware LIFO stack.
- Shares the single stack between two requesters: the call/return unit on port 0 and the interrupt/context unit on port 1.
- Tracks occupancy and rejects overflow and underflow, so the stack never silently drops the bottom entry or pops an invalid entry.
- Drives the stack's push, pop, din and synchronous Reset pins, and returns popped data with a one-cycle acknowledge.

Parameters:
- n, 8, data width. Must match the stack instance.
- DEPTH, 4, number of stack locations. The depth counter saturates at DEPTH.

Ports:
- Clock  in  1  rising-edge clock, shared with the stack.
- Resetn  in  1  asynchronous, active-low reset.
- req0  in  1  request from port 0. Held high until ack0.
- op0  in  1  port 0 operation: 1 = push, 0 = pop.
- wdata0  in  n  port 0 push data.
- req1  in  1  request from port 1. Held high until ack1.
- op1  in  1  port 1 operation: 1 = push, 0 = pop.
- wdata1  in  n  port 1 push data.
- ack0  out  1  one-cycle completion pulse to port 0.
- ack1  out  1  one-cycle completion pulse to port 1.
- rdata  out  n  pop result. Valid only while ack0 or ack1 is high.
- err  out  1  rejected operation. Valid only while ack0 or ack1 is high.
- depth  out  3  current occupancy, 0..DEPTH.
- full  out  1  depth == DEPTH.
- empty  out  1  depth == 0.
- stk_push  out  1  to stack push.
- stk_pop  out  1  to stack pop.
- stk_rst  out  1  to stack Reset (active-high, synchronous).
- stk_din  out  n  to stack din.
- stk_dout  in  n  from stack dout.

Behaviour:
- All outputs are registered or decoded from registered state.
- Reset (Resetn low, asynchronous):
  - state = CLR, depth = 0, stk_rst = 1.
  - ack0, ack1, err, stk_push, stk_pop = 0; rdata = 0; stk_din = 0.
- FSM states: CLR, IDLE, ISSUE, RESP.
- CLR:
  - stk_rst stays high for the first Clock edge after Resetn rises, which clears all stack locations.
  - Next state is IDLE.
  - Requests are ignored in CLR.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise arbitrate (see Optional Feature), latch the winner's id, op and wdata into gnt_id, gnt_op and stk_din, and evaluate legality.
  - An operation is illegal if it is a push with depth == DEPTH, or a pop with depth == 0.
  - Illegal: set err_r = 1 and go to RESP. No stack strobe is issued.
  - Legal: go to ISSUE.
- ISSUE (exactly one cycle):
  - stk_push = gnt_op; stk_pop = !gnt_op.
  - On the closing edge, depth increments on a push and decrements on a pop.
  - Next state is RESP.
- RESP (exactly one cycle):
  - ack[gnt_id] = 1.
  - err = err_r.
  - rdata = stk_dout for a legal pop (the stack registers the popped value on the ISSUE edge); otherwise rdata = 0.
  - Clear err_r. Next state is IDLE.
- Latency is 3 cycles from req to ack for a legal operation and 2 cycles for an illegal one. Maximum throughput is one operation per 3 cycles.
- Handshake:
  - A requester samples ack on the edge where it is high and drops req, or presents a new operation, in the following cycle.
  - A losing requester keeps req high and is serviced later; it must not change op or wdata while waiting.
  - A req dropped before its ack is undefined use. The controller is not required to detect it.
- depth, full and empty update only on the ISSUE edge. Simultaneous requests cannot corrupt depth because only one operation is issued at a time.
- Reset mid-operation (any state):
  - Immediate return to CLR; the in-flight op is abandoned.
  - No ack is issued for it; depth returns to 0 and the stack is cleared.
- stk_push and stk_pop are never high together, and never high outside ISSUE.

Optional Feature:
- Macro: CJB_STACK_CTRL_RR_EN.
- Defined: round-robin arbitration.
  - A last_gnt flag records the most recently serviced port, including rejected operations.
  - When both reqs are high in IDLE, the other port wins.
  - last_gnt resets to 1, so port 0 wins the first tie.
- Undefined: fixed priority; port 1 (interrupt) always wins a tie, and last_gnt is not implemented.
- Single-requester behaviour is identical in both builds.

Test Plan:
1. Reset release:
   - Stimulus: hold Resetn low 3 cycles, then release.
   - Required response: stk_rst = 1 through the first edge after release; depth = 0, empty = 1, full = 0; ack0 = 0 and ack1 = 0 throughout.
2. Push then pop on port 0:
   - Stimulus: push 0xA5, then pop.
   - Required response:
     - Push: stk_push pulses 1 cycle, ack0 at cycle 3, depth goes 0 to 1.
     - Pop: ack0 with rdata = 0xA5 and err = 0, depth back to 0.
3. LIFO fill and overflow:
   - Stimulus: push 0x11, 0x22, 0x33, 0x44, then push 0x55, then pop 4 times.
   - Required response:
     - After 4 pushes: full = 1.
     - Fifth push: ack with err = 1 at cycle 2, stk_push never asserted, depth stays 4.
     - Pops: rdata = 0x44, 0x33, 0x22, 0x11.
4. Underflow:
   - Stimulus: pop when empty.
   - Required response: ack with err = 1 and rdata = 0; stk_pop never asserted; depth stays 0.
5. Contention:
   - Stimulus: req0 (push 0x01) and req1 (push 0x02) asserted in the same cycle, held until acked.
   - Required response:
     - Fixed build: ack1 first, then ack0; pops return 0x01, then 0x02.
     - RR build: ack0 first, then ack1; continued contention alternates ports.
6. Reset mid-operation:
   - Stimulus: assert Resetn low during the ISSUE state of a push.
   - Required response: no ack issued; depth = 0 after release; a subsequent pop returns err = 1.
